// File: rtl/spi_initiator.sv
// ---------------------------------------------------------------------------
// spi_initiator
//   Mode-0, MSB-first SPI initiator. A one-cycle start launches a full-duplex
//   transfer of WIDTH bits. Completion is reported with a one-cycle done pulse
//   and the received word on rx_data_o.
//
// Parameters
//   WIDTH   : transfer length in bits (>= 2)
//   CLK_DIV : serial clock half-period in clk_i cycles (>= 1)
//
// Ports
//   clk_i       : system clock, rising edge
//   n_reset_i   : asynchronous active-low reset
//   start_i     : transfer request, sampled only while idle
//   tx_data_i   : word to send, latched when start_i is accepted
//   rx_data_o   : last received word, updated only at completion
//   busy_o      : high while a transfer is in progress
//   done_o      : one-cycle completion pulse
//   sclk_o      : serial clock, idles low
//   cs_o        : active-low chip select, idles high
//   mosi_o      : serial data out, MSB first, low while cs_o is high
//   miso_i      : serial data in, sampled on sclk_o rising edges
//
// Build option
//   SPI_INITIATOR_LOOPBACK_EN : when defined, miso_i is ignored and mosi_o is
//   fed back internally as the sampled bit; pin timing is unchanged.
// ---------------------------------------------------------------------------
module spi_initiator #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk_i,
    input  logic             n_reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             cs_o,
    output logic             mosi_o,
    input  logic             miso_i
);

    localparam int unsigned PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Bit counter must reach WIDTH itself, so it needs WIDTH+1 codes.
    localparam int unsigned BIT_W = $clog2(WIDTH + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               miso_bit_q, miso_bit_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   rx_q, rx_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               phase_last;
    logic               sample_bit;

    // Source of the bit captured on each sclk rising edge.
`ifdef SPI_INITIATOR_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_i;
    assign sample_bit  = mosi_q;
`else
    assign sample_bit  = miso_i;
`endif

    assign phase_last = (phase_q == PH_LAST);

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        miso_bit_d = miso_bit_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        rx_d       = rx_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sr_d    = tx_data_i;
                    phase_d = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                if (phase_last) begin
                    phase_d    = '0;
                    sclk_d     = 1'b1;
                    miso_bit_d = sample_bit;
                    state_d    = S_HIGH;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            S_HIGH: begin
                // Falling sclk edge: shift in the sampled bit, expose next MSB.
                if (phase_last) begin
                    phase_d = '0;
                    sclk_d  = 1'b0;
                    sr_d    = {sr_q[WIDTH-2:0], miso_bit_q};
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = S_LOW;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            S_LOW: begin
                // The last LOW phase doubles as chip-select hold time.
                if (phase_last) begin
                    phase_d = '0;
                    if (bit_q == BIT_LAST) begin
                        cs_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rx_d    = sr_q;
                        state_d = S_IDLE;
                    end else begin
                        sclk_d     = 1'b1;
                        miso_bit_d = sample_bit;
                        state_d    = S_HIGH;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // mosi is registered from next-state so it moves together with cs/sclk.
        mosi_d = cs_d ? 1'b0 : sr_d[WIDTH-1];
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            miso_bit_q <= 1'b0;
            phase_q    <= '0;
            bit_q      <= '0;
            rx_q       <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            miso_bit_q <= miso_bit_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            rx_q       <= rx_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rx_data_o = rx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign sclk_o    = sclk_q;
    assign cs_o      = cs_q;
    assign mosi_o    = mosi_q;

endmodule
